// File: rtl/demo01_sweep_ctrl.sv
// Sweep sequencer: walks all 32 vectors into a 5-input function block,
// captures its truth table and compares it against a golden table.
module demo01_sweep_ctrl #(
  parameter int          SETTLE   = 2,
  parameter logic [31:0] EXPECTED = 32'hFF00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  input  logic        F,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_valid,
  output logic [4:0]  fail_idx,
  output logic [31:0] tt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t        state, state_nx;
  logic [4:0]    idx;
  logic [CW-1:0] cnt;
  logic          settled;
  logic          accept;
  logic [4:0]    vec;
  logic [4:0]    lowest_diff;

  assign settled = (cnt == CW'(SETTLE - 1));
  assign accept  = start && !abort;

  // Lowest set bit of the mismatch mask; scanning downward leaves the lowest one.
  always_comb begin
    lowest_diff = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (tt[i] != EXPECTED[i]) lowest_diff = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    vec      = 5'd0;
    case (state)
      IDLE:  if (accept) state_nx = DRIVE;
      DRIVE: begin
        vec = idx;
        if (abort)                          state_nx = IDLE;
        else if (settled && idx == 5'd31)   state_nx = CHECK;
      end
      CHECK: begin
        vec      = idx;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign {A, B, C, D, E} = vec;

  // Datapath: abort takes priority over the sample due on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 5'd0;
      cnt        <= '0;
      tt         <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_idx   <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx        <= 5'd0;
            cnt        <= '0;
            tt         <= 32'd0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= 5'd0;
            busy       <= 1'b1;
          end
        end
        DRIVE: begin
          if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
          end else if (settled) begin
            tt[idx] <= F;
            cnt     <= '0;
            if (idx != 5'd31) idx <= idx + 5'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          pass       <= (tt == EXPECTED);
          fail_valid <= (tt != EXPECTED);
          fail_idx   <= lowest_diff;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_demo01_sweep_ctrl.sv
// Bench for demo01_sweep_ctrl: the function block is a truth-table lookup,
// results are predicted directly from the table and the vector timing rules.
module tb_demo01_sweep_ctrl;

  localparam logic [31:0] GOLD = 32'hFF00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, start1, abort1;
  logic        a, b, c, d, e, f, busy, done, pass, fail_valid;
  logic [4:0]  fail_idx, vec;
  logic [31:0] tt;
  logic        a1, b1, c1, d1, e1, f1, busy1, done1, pass1, fail_valid1;
  logic [4:0]  fail_idx1, vec1;
  logic [31:0] tt1;
  logic [31:0] table0, table1;

  int checks = 0;
  int errors = 0;

  assign vec  = {a, b, c, d, e};
  assign vec1 = {a1, b1, c1, d1, e1};
  assign f    = table0[vec];
  assign f1   = table1[vec1];

  demo01_sweep_ctrl #(.SETTLE(2), .EXPECTED(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .A(a), .B(b), .C(c), .D(d), .E(e), .F(f),
    .busy(busy), .done(done), .pass(pass), .fail_valid(fail_valid),
    .fail_idx(fail_idx), .tt(tt)
  );

  demo01_sweep_ctrl #(.SETTLE(1), .EXPECTED(GOLD)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_valid(fail_valid1),
    .fail_idx(fail_idx1), .tt(tt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] and_ab_table();
    logic [31:0] t;
    logic [4:0]  v;
    t = 32'd0;
    for (int i = 0; i < 32; i++) begin
      v    = 5'(i);
      t[i] = v[4] & v[3];
    end
    return t;
  endfunction

  function automatic logic [4:0] first_mismatch(input logic [31:0] t);
    for (int i = 0; i < 32; i++) if (t[i] != GOLD[i]) return 5'(i);
    return 5'd0;
  endfunction

  // Vector expected on A..E k edges after the accepting edge, SETTLE=2.
  function automatic int exp_vec2(input int k);
    if (k < 64)  return k / 2;
    if (k == 64) return 31;
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".pass"}, 32'(pass), 32'd0);
    chk({tag, ".fail_valid"}, 32'(fail_valid), 32'd0);
    chk({tag, ".fail_idx"}, 32'(fail_idx), 32'd0);
    chk({tag, ".tt"}, tt, 32'd0);
    chk({tag, ".vec"}, 32'(vec), 32'd0);
  endtask

  task automatic run_full(input string tag, input int restart_at);
    int   done_at, dones;
    logic order_ok;
    start = 1'b1;
    step;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    order_ok = (vec === 5'd0);
    done_at  = -1;
    dones    = 0;
    for (int k = 1; k <= 75; k++) begin
      start = (restart_at > 0 && k == restart_at);
      step;
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
      if (k <= 65 && vec !== 5'(exp_vec2(k))) order_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, ".done_at"}, 32'(done_at), 32'd65);
    chk({tag, ".dones"}, 32'(dones), 32'd1);
    chk({tag, ".order"}, 32'(order_ok), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".tt"}, tt, table0);
    chk({tag, ".pass"}, 32'(pass), 32'(table0 == GOLD));
    chk({tag, ".fail_valid"}, 32'(fail_valid), 32'(table0 != GOLD));
    chk({tag, ".fail_idx"}, 32'(fail_idx), 32'(first_mismatch(table0)));
  endtask

  // Abort raised after edge E0+a_k, so it is sampled on edge E0+a_k+1.
  task automatic run_abort(input string tag, input int a_k);
    logic [31:0] exp_tt;
    int          dones;
    exp_tt = 32'd0;
    for (int v = 0; v < 32; v++) if (2 * (v + 1) <= a_k) exp_tt[v] = table0[v];
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (a_k) step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".vec"}, 32'(vec), 32'd0);
    chk({tag, ".tt"}, tt, exp_tt);
    chk({tag, ".pass"}, 32'(pass), 32'd0);
    chk({tag, ".fail_valid"}, 32'(fail_valid), 32'd0);
    dones = 0;
    repeat (70) begin
      if (done === 1'b1) dones++;
      step;
    end
    chk({tag, ".no_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    int          r1, r2, ok, period;
    logic [31:0] prev_tt, tt1_first;
    logic        pass1_first;
    start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    table0 = and_ab_table();
    table1 = and_ab_table();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    step; step;
    rst_n = 1'b1;
    step;
    check_zero("post_reset");

    run_full("and_ab", 0);
    table0 = 32'd0;
    run_full("stuck0", 0);
    chk("stuck0.fail_idx24", 32'(fail_idx), 32'd24);

    table0 = and_ab_table();
    run_abort("abort10", 10);
    table0 = $urandom;
    run_abort("abort_rand", $urandom_range(3, 60));

    table0 = and_ab_table();
    run_full("restart20", 20);

    for (int n = 0; n < 3; n++) begin
      r1 = $urandom_range(0, 31);
      r2 = $urandom_range(0, 31);
      case (n)
        0: table0 = $urandom;
        1: table0 = GOLD ^ (32'd1 << r1);
        default: table0 = GOLD ^ (32'd1 << r1) ^ (32'd1 << r2);
      endcase
      run_full($sformatf("rand%0d", n), 0);
    end

    // Start and abort together in IDLE: nothing starts, results untouched.
    prev_tt = tt;
    start = 1'b1; abort = 1'b1;
    step;
    chk("start_abort.busy", 32'(busy), 32'd0);
    step;
    chk("start_abort.busy2", 32'(busy), 32'd0);
    chk("start_abort.tt", tt, prev_tt);
    start = 1'b0; abort = 1'b0;
    step;

    // Abort arriving during CHECK is ignored.
    table0 = and_ab_table();
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (64) step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("abort_check.done", 32'(done), 32'd1);
    chk("abort_check.pass", 32'(pass), 32'd1);
    chk("abort_check.tt", tt, GOLD);
    step;
    chk("abort_check.done_width", 32'(done), 32'd0);

    // Asynchronous reset mid-sweep.
    table0 = and_ab_table();
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (30) step;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    step;
    rst_n = 1'b1;
    step;
    run_full("after_reset", 0);

    // SETTLE=1 instance with start held high: back-to-back sweeps.
    table1 = $urandom;
    start1 = 1'b1;
    step;
    ok = 1;
    tt1_first = 32'd0;
    pass1_first = 1'b0;
    for (int k = 1; k <= 102; k++) begin
      step;
      period = k % 34;
      if (done1 !== (period == 33)) ok = 0;
      if (busy1 !== (period <= 32)) ok = 0;
      if (vec1 !== 5'((period <= 31) ? period : ((period == 32) ? 31 : 0))) ok = 0;
      if (k == 33) begin
        tt1_first   = tt1;
        pass1_first = pass1;
      end
    end
    start1 = 1'b0;
    chk("settle1.timing", 32'(ok), 32'd1);
    chk("settle1.tt", tt1_first, table1);
    chk("settle1.pass", 32'(pass1_first), 32'(table1 == GOLD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
